gray_encoder_system: RTL and testbench
======================================

# gray_encoder_system

Counterpart to the Gray decoder path: a sequential binary-to-Gray encoder for the FPGA board. It holds a 4-bit binary value, either loaded from switches by a debounced button or auto-stepped by a prescaled counter. It presents the Gray code on `gray_out` and the LEDs, and shows the binary value on the 7-segment display. Its `gray_out` feeds the decoder system's `gray_in` for loopback testing.

## Interface
- `TICK_DIV`, default 27_000_000: clk cycles per auto-step (1 Hz at 27 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 270_000: cycles a button level must be stable to be accepted (10 ms); must be ≥ 1.
- `clk`  in  1  single system clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bin_in`  in  4  binary value from switches; may be asynchronous, sampled only on load.
- `btn_load`  in  1  raw button, asynchronous, active-high; each debounced press loads `bin_in`.
- `btn_mode`  in  1  raw button, asynchronous, active-high; each debounced press toggles HOLD/AUTO.
- `gray_out`  out  4  registered Gray code of the internal count.
- `gray_valid`  out  1  one-cycle pulse, coincident with each `gray_out` update (including a re-load of an equal value).
- `led`  out  4  equals `gray_out`.
- `seg`  out  7  active-low `{g,f,e,d,c,b,a}` hex digit of the binary count.

## Operation
- `count`: 4-bit binary register. Gray encoding is `g = count ^ (count >> 1)`.
- Button path, identical per button:
  - 2-FF synchronizer, then debounce counter, then rising-edge detect.
  - The edge detect produces a 1-cycle pulse (`load_p`, `mode_p`).
  - A level differing from the debounced level for `DEBOUNCE_CYCLES` consecutive synchronized samples replaces it.
  - A shorter glitch resets the counter and produces no pulse.
- FSM states:
  - HOLD (reset state): `count` is static.
  - AUTO: the prescaler runs and each tick increments `count`.
- FSM transitions: `mode_p` in HOLD goes to AUTO; `mode_p` in AUTO goes to HOLD; all other cases self-loop.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in AUTO.
  - `tick` is asserted in the cycle the prescaler equals `TICK_DIV`-1, then the prescaler wraps to 0.
  - Cleared to 0 on entering HOLD, on `load_p`, and on reset.
- Count update priority:
  1. `load_p` sets `count` to `bin_in`.
  2. Otherwise `tick` (AUTO only) sets `count` to `count + 1`, mod 16.
  3. Otherwise `count` holds.
- Simultaneous events:
  - `load_p` with `tick`: load wins and the tick is discarded.
  - `load_p` with `mode_p`: both take effect; AUTO resumes counting from the loaded value.
- Wrap-around: 15 → 0, so Gray 1000 → 0000. This is a single-bit change, which tests must check.
- `seg` is combinational from `count`. Patterns come from the package table, e.g. 0 = 1000000, 1 = 1111001, A = 0001000, F = 0001110.

## Timing
- Reset values: `count`=0, `gray_out`=0000, `led`=0000, `gray_valid`=0, `seg`=1000000, FSM HOLD, prescaler 0, debounced levels 0, debounce counters 0.
- Reset mid-operation: all of the above are restored on the next edge. Any pending debounce is discarded, and a button still held after reset must be re-debounced before it produces a pulse.
- Button latency:
  - Raw button high, stable, from cycle 0.
  - Pulse is high in cycle `DEBOUNCE_CYCLES`+2, for exactly 1 cycle.
  - Holding the button never produces a second pulse; release-and-press is required.
- Count latency: `count` changes on the edge ending the `load_p`/`tick` cycle.
- Gray latency: `gray_out` and `gray_valid` follow `count` by one cycle.
- Total press-to-`gray_out` latency: `DEBOUNCE_CYCLES`+4 cycles.
- `seg` follows `count` combinationally, one cycle ahead of `gray_out`.
- AUTO step period: exactly `TICK_DIV` cycles. The first tick comes `TICK_DIV` cycles after entry to AUTO or after a load.

## Structure
- Package `gray_pkg`:
  - `typedef enum logic {HOLD, AUTO} enc_state_t`
  - 16-entry 7-segment constant table
  - `function bin2gray`
- One sub-module, `btn_debounce`:
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `btn_raw`, `pulse`.
  - Instanced twice.
- Prescaler, FSM, count, and output registers live in the top level.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset: assert `rst` 2 cycles with buttons low → `gray_out`=0000, `led`=0000, `seg`=1000000, `gray_valid`=0, state HOLD.
- Load: `bin_in`=0110, hold `btn_load` 8 cycles → exactly one `gray_valid` pulse, `gray_out`=0101, `seg`=6 pattern, 7 cycles after press start. A 2-cycle glitch → no change.
- AUTO count with wrap:
  - Load 1101, then press `btn_mode`.
  - Expect `gray_out` sequence 1011, 1001, 1000, 0000, 0001, steps exactly 4 cycles apart.
  - Each step must differ from the previous one in exactly 1 bit.
- Collision:
  - Force the `load_p` press to land in the same cycle as `tick`.
  - Load value is applied, no increment occurs.
  - Next step comes 4 cycles later.
- Mode toggle back: press `btn_mode` again in AUTO → `count` frozen, no `gray_valid` for 20 cycles.
- Reset mid-AUTO with `btn_load` held → outputs return to reset values. The held button produces a pulse only after a full debounce from the reset release.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types, 7-segment table and Gray helper for the binary-to-Gray encoder board design.
package gray_pkg;

    typedef enum logic {HOLD, AUTO} enc_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_encoder_system_btn_debounce.sv
// Raw button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q, level_q, level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_d;

    // The counter tracks how many consecutive samples disagreed with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/gray_encoder_system.sv
// 4-bit binary counter loaded from switches or auto-stepped, presented as Gray code and hex digit.
module gray_encoder_system
    import gray_pkg::*;
#(
    parameter int TICK_DIV        = 27_000_000,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bin_in,
    input  logic       btn_load,
    input  logic       btn_mode,
    output logic [3:0] gray_out,
    output logic       gray_valid,
    output logic [3:0] led,
    output logic [6:0] seg
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    enc_state_t    state_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    count_q, count_d, gray_q;
    logic          upd_q, valid_q;
    logic          load_p, mode_p, tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .pulse(load_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk(clk), .rst(rst), .btn_raw(btn_mode), .pulse(mode_p)
    );

    assign tick = (state_q == AUTO) && (pre_q == PRE_LAST);

    // Prescaler restarts on a load and whenever AUTO is not continuing into the next cycle
    always_comb begin
        pre_d = '0;
        if ((state_q == AUTO) && !mode_p && !load_p && !tick) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (load_p) begin
            count_d = bin_in;
        end else if (tick) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
        end else if (mode_p) begin
            state_q <= (state_q == HOLD) ? AUTO : HOLD;
        end
    end

    // upd_q remembers that count changed so gray_valid lines up with the new gray_out
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            count_q <= '0;
            upd_q   <= 1'b0;
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            upd_q   <= load_p | tick;
            gray_q  <= bin2gray(count_q);
            valid_q <= upd_q;
        end
    end

    assign gray_out   = gray_q;
    assign led        = gray_q;
    assign gray_valid = valid_q;
    assign seg        = SEG_TABLE[count_q];

endmodule

// File: tb/tb_gray_encoder_system.sv
// Directed plus randomized bench for gray_encoder_system against a cycle-level behavioural model.
module tb_gray_encoder_system;
    localparam int TICK = 4;
    localparam int DEB  = 3;

    logic       clk;
    logic       rst;
    logic [3:0] bin_in;
    logic       btn_load;
    logic       btn_mode;
    logic [3:0] gray_out;
    logic       gray_valid;
    logic [3:0] led;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 0;

    gray_encoder_system #(.TICK_DIV(TICK), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .btn_load(btn_load), .btn_mode(btn_mode),
        .gray_out(gray_out), .gray_valid(gray_valid), .led(led), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] SEG_EXP [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Behavioural model state
    int mCount, mGray, mUpd, mValid, mPhase;
    bit mAuto;
    bit mLevL, mPrevL, mP1L, mP2L;
    bit mLevM, mPrevM, mP1M, mP2M;
    bit histL[$];
    bit histM[$];

    function automatic bit settled(input bit q[$], input bit lvl);
        if (q.size() < DEB) return 1'b0;
        for (int k = q.size() - DEB; k < q.size(); k++) begin
            if (q[k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    // The model advances on the same edge as the design using the inputs held across it
    always @(posedge clk) begin : model
        bit lp, mp, tk, s;
        if (rst) begin
            mCount = 0; mGray = 0; mUpd = 0; mValid = 0; mPhase = 0; mAuto = 1'b0;
            mLevL = 1'b0; mPrevL = 1'b0; mP1L = 1'b0; mP2L = 1'b0;
            mLevM = 1'b0; mPrevM = 1'b0; mP1M = 1'b0; mP2M = 1'b0;
            histL.delete();
            histM.delete();
        end else begin
            lp = mLevL && !mPrevL;
            mp = mLevM && !mPrevM;
            tk = mAuto && (mPhase == TICK - 1);
            mGray  = mCount ^ (mCount / 2);
            mValid = mUpd;
            if (lp) begin
                mCount = int'(bin_in);
                mUpd   = 1;
            end else if (tk) begin
                mCount = (mCount + 1) % 16;
                mUpd   = 1;
            end else begin
                mUpd = 0;
            end
            mPhase = (mAuto && !mp && !lp) ? (mPhase + 1) % TICK : 0;
            if (mp) mAuto = !mAuto;

            mPrevL = mLevL;
            s = mP2L; mP2L = mP1L; mP1L = btn_load;
            histL.push_back(s);
            if (histL.size() > DEB) void'(histL.pop_front());
            if (settled(histL, mLevL)) begin
                mLevL = !mLevL;
                histL.delete();
            end

            mPrevM = mLevM;
            s = mP2M; mP2M = mP1M; mP1M = btn_mode;
            histM.push_back(s);
            if (histM.size() > DEB) void'(histM.pop_front());
            if (settled(histM, mLevM)) begin
                mLevM = !mLevM;
                histM.delete();
            end
        end
    end

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s (cycle %0d): observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("gray_out model", 8'(gray_out), 8'(mGray));
        checkVal("led model", 8'(led), 8'(mGray));
        checkVal("gray_valid model", 8'(gray_valid), 8'(mValid));
        checkVal("seg model", 8'(seg), 8'(SEG_EXP[mCount[3:0]]));
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (started) checkOutput();
        end
    endtask

    initial begin
        int nValid;
        int found;
        int evCyc[$];
        logic [3:0] evVal[$];
        logic [3:0] prevG;
        logic [3:0] expSeq [4];
        expSeq[0] = 4'b1001; expSeq[1] = 4'b1000; expSeq[2] = 4'b0000; expSeq[3] = 4'b0001;

        rst = 1'b1; btn_load = 1'b0; btn_mode = 1'b0; bin_in = 4'h0;
        applyStimulus(2);
        started = 1'b1;
        checkVal("reset gray_out", 8'(gray_out), 8'h00);
        checkVal("reset led", 8'(led), 8'h00);
        checkVal("reset seg", 8'(seg), 8'h40);
        checkVal("reset gray_valid", 8'(gray_valid), 8'h00);
        rst = 1'b0;
        nValid = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            nValid += int'(gray_valid);
        end
        checkVal("hold quiet after reset", 8'(nValid), 8'h00);

        $display("[TB] load 0110");
        bin_in = 4'b0110; btn_load = 1'b1;
        nValid = 0;
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(1);
            nValid += int'(gray_valid);
            if (i == 6) checkVal("load not early", 8'(gray_valid), 8'h00);
            if (i == 7) begin
                checkVal("load valid at 7", 8'(gray_valid), 8'h01);
                checkVal("load gray", 8'(gray_out), 8'h05);
                checkVal("load seg", 8'(seg), 8'h02);
            end
            if (i == 8) btn_load = 1'b0;
        end
        checkVal("load single pulse", 8'(nValid), 8'h01);

        $display("[TB] two-cycle glitch");
        bin_in = 4'b1111; btn_load = 1'b1;
        applyStimulus(2);
        btn_load = 1'b0;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            nValid += int'(gray_valid);
        end
        checkVal("glitch no pulse", 8'(nValid), 8'h00);
        checkVal("glitch gray kept", 8'(gray_out), 8'h05);

        $display("[TB] auto count with wrap");
        bin_in = 4'b1101; btn_load = 1'b1;
        applyStimulus(8);
        btn_load = 1'b0;
        applyStimulus(4);
        checkVal("auto start gray", 8'(gray_out), 8'h0B);
        btn_mode = 1'b1;
        for (int i = 1; i <= 60 && evVal.size() < 4; i++) begin
            applyStimulus(1);
            if (i == 8) btn_mode = 1'b0;
            if (gray_valid === 1'b1) begin
                evCyc.push_back(i);
                evVal.push_back(gray_out);
            end
        end
        btn_mode = 1'b0;
        checkVal("auto step count", 8'(evVal.size()), 8'h04);
        if (evCyc.size() > 0) checkVal("auto first step delay", 8'(evCyc[0]), 8'd11);
        prevG = 4'b1011;
        for (int k = 0; k < evVal.size(); k++) begin
            checkVal("auto step value", 8'(evVal[k]), 8'(expSeq[k]));
            checkVal("auto single bit change", 8'($countones(evVal[k] ^ prevG)), 8'h01);
            if (k > 0) checkVal("auto step period", 8'(evCyc[k] - evCyc[k-1]), 8'(TICK));
            prevG = evVal[k];
        end

        $display("[TB] load colliding with tick");
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            applyStimulus(1);
            if (mPhase == 2) found = 1;
        end
        checkVal("collision alignment found", 8'(found), 8'h01);
        bin_in = 4'h9; btn_load = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1);
            if (i == 8) btn_load = 1'b0;
            if (i == 7) begin
                checkVal("collision valid", 8'(gray_valid), 8'h01);
                checkVal("collision load wins", 8'(gray_out), 8'h0D);
            end
            if (i >= 8 && i <= 10) checkVal("collision no extra step", 8'(gray_valid), 8'h00);
            if (i == 11) begin
                checkVal("collision next step valid", 8'(gray_valid), 8'h01);
                checkVal("collision next step gray", 8'(gray_out), 8'h0F);
            end
        end

        $display("[TB] mode back to hold");
        btn_mode = 1'b1;
        nValid = 0;
        for (int i = 1; i <= 28; i++) begin
            applyStimulus(1);
            if (i == 8) btn_mode = 1'b0;
            if (i >= 9) nValid += int'(gray_valid);
        end
        checkVal("hold frozen 20 cycles", 8'(nValid), 8'h00);

        $display("[TB] reset mid-auto with load held");
        btn_mode = 1'b1;
        applyStimulus(8);
        btn_mode = 1'b0;
        applyStimulus(10);
        bin_in = 4'h3; btn_load = 1'b1;
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(2);
        checkVal("midreset gray_out", 8'(gray_out), 8'h00);
        checkVal("midreset led", 8'(led), 8'h00);
        checkVal("midreset seg", 8'(seg), 8'h40);
        checkVal("midreset gray_valid", 8'(gray_valid), 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1);
            if (i < 7) checkVal("redebounce quiet", 8'(gray_valid), 8'h00);
            if (i == 7) begin
                checkVal("redebounce valid", 8'(gray_valid), 8'h01);
                checkVal("redebounce gray", 8'(gray_out), 8'h02);
            end
        end
        btn_load = 1'b0;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bin_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) btn_load = ~btn_load;
            if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
            applyStimulus(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
